// File: rtl/dual_slope_seq.sv
`default_nettype none
// ============================================================================
//  Module      : dual_slope_seq
//  Description : Phase sequencer for the MC14433 dual-slope conversion
//                datapath. It steps the integrator through auto-zero,
//                signal-integrate and reference de-integrate, and counts the
//                de-integrate time until the comparator crosses zero. At end
//                of conversion it latches count, polarity and over/under-range
//                (when DU is high), then pulses EOC.
//  Revision    : 1.0  initial release
// ============================================================================
module dual_slope_seq #(
    parameter int CW        = 12,
    parameter int AZ_CNT    = 1000,
    parameter int INT_CNT   = 1000,
    parameter int DEINT_MAX = 1999,
    parameter int UR_LIM    = 180
) (
    input  logic          CP15,
    input  logic          R,
    input  logic          RUN,
    input  logic          COMP,
    input  logic          DU,
    output logic          AZ_EN,
    output logic          INT_EN,
    output logic          DEI_EN,
    output logic          REF_POL,
    output logic          EOC,
    output logic          BUSY,
    output logic [CW-1:0] RESULT,
    output logic          POL,
    output logic          OVR,
    output logic          UR
);

    // Sequencer states
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_AZ    = 3'd1;
    localparam logic [2:0] S_INT   = 3'd2;
    localparam logic [2:0] S_DEINT = 3'd3;
    localparam logic [2:0] S_EOC   = 3'd4;

    // Terminal counts, pre-sized to the counter width
    localparam logic [CW-1:0] AZ_LAST    = CW'(AZ_CNT - 1);
    localparam logic [CW-1:0] INT_LAST   = CW'(INT_CNT - 1);
    localparam logic [CW-1:0] DEINT_TOP  = CW'(DEINT_MAX);

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic          pol_r;
    logic [CW-1:0] res_r;
    logic          ovr_r;
    logic          ur_next;

    // Underrange only applies to an in-range result; compared at 32 bits so a
    // limit wider than the counter cannot be truncated.
    assign ur_next = (32'(res_r) < 32'(UR_LIM)) && !ovr_r;

    // Phase enables are pure decodes of the registered state
    assign AZ_EN   = (state == S_AZ);
    assign INT_EN  = (state == S_INT);
    assign DEI_EN  = (state == S_DEINT);
    assign EOC     = (state == S_EOC);
    assign BUSY    = (state != S_IDLE);
    assign REF_POL = pol_r;

    // Phase sequencing, phase counter and end-of-integrate/de-integrate captures
    always_ff @(posedge CP15) begin
        if (R) begin
            state <= S_IDLE;
            cnt   <= '0;
            pol_r <= 1'b0;
            res_r <= '0;
            ovr_r <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (RUN) begin
                        state <= S_AZ;
                    end
                end
                S_AZ: begin
                    if (cnt == AZ_LAST) begin
                        state <= S_INT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_INT: begin
                    if (cnt == INT_LAST) begin
                        // Input polarity is the comparator state after integrating
                        pol_r <= COMP;
                        state <= S_DEINT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DEINT: begin
                    if (COMP != pol_r) begin
                        // Zero crossing wins even in the full-scale cycle
                        res_r <= cnt;
                        ovr_r <= 1'b0;
                        state <= S_EOC;
                    end else if (cnt == DEINT_TOP) begin
                        res_r <= DEINT_TOP;
                        ovr_r <= 1'b1;
                        state <= S_EOC;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_EOC: begin
                    cnt   <= '0;
                    state <= RUN ? S_AZ : S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Display-side result registers, loaded at the end of the EOC cycle when DU is set
    always_ff @(posedge CP15) begin
        if (R) begin
            RESULT <= '0;
            POL    <= 1'b0;
            OVR    <= 1'b0;
            UR     <= 1'b0;
        end else if (state == S_EOC && DU) begin
            RESULT <= res_r;
            POL    <= pol_r;
            OVR    <= ovr_r;
            UR     <= ur_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dual_slope_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dual_slope_seq
//  Description : Self-checking bench for dual_slope_seq. Table of directed
//                conversions plus randomized conversions, all checked against
//                a conversion-level timing/result model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dual_slope_seq;

    localparam int CW = 12;
    localparam int A  = 4;
    localparam int I  = 5;
    localparam int DM = 20;
    localparam int UL = 3;

    logic          CP15 = 1'b0;
    logic          R, RUN, COMP, DU;
    logic          AZ_EN, INT_EN, DEI_EN, REF_POL, EOC, BUSY, POL, OVR, UR;
    logic [CW-1:0] RESULT;

    dual_slope_seq #(
        .CW(CW), .AZ_CNT(A), .INT_CNT(I), .DEINT_MAX(DM), .UR_LIM(UL)
    ) dut (
        .CP15(CP15), .R(R), .RUN(RUN), .COMP(COMP), .DU(DU),
        .AZ_EN(AZ_EN), .INT_EN(INT_EN), .DEI_EN(DEI_EN), .REF_POL(REF_POL),
        .EOC(EOC), .BUSY(BUSY), .RESULT(RESULT), .POL(POL), .OVR(OVR), .UR(UR)
    );

    always #5 CP15 = ~CP15;

    int checks = 0;
    int passes = 0;

    // Model of the display registers
    logic [CW-1:0] m_res;
    logic          m_pol, m_ovr, m_ur;

    // Phase vector {AZ_EN, INT_EN, DEI_EN, EOC, BUSY}
    localparam logic [4:0] P_IDLE = 5'b00000;
    localparam logic [4:0] P_AZ   = 5'b10001;
    localparam logic [4:0] P_INT  = 5'b01001;
    localparam logic [4:0] P_DEI  = 5'b00101;
    localparam logic [4:0] P_EOC  = 5'b00011;

    typedef struct {
        bit            pol;
        int            k;        // DEINT cycle index of first crossing
        bit            du;
        bit            keep;     // keep RUN high through EOC
        int            drop_at;  // conversion cycle at which RUN is dropped (0 = none)
        logic [CW-1:0] e_res;
        bit            e_pol;
        bit            e_ovr;
        bit            e_ur;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge CP15);
        #1;
    endtask

    function automatic logic [4:0] phases();
        return {AZ_EN, INT_EN, DEI_EN, EOC, BUSY};
    endfunction

    // One conversion. Cycle n is the state after the n-th edge from the AZ entry
    // edge; cycle L is EOC, cycle L+1 is the first cycle after it.
    task automatic convert(input vec_t v, input bit chained, input string tag,
                           output bit running);
        int            res;
        int            len;
        int            bad_cyc;
        int            refbad;
        logic [4:0]    exp_p;
        logic [4:0]    bad_got;
        logic [4:0]    bad_exp;
        res     = (v.k <= DM) ? v.k : DM;
        len     = A + I + (res + 1) + 1;
        bad_cyc = 0;
        refbad  = 0;
        bad_got = '0;
        bad_exp = '0;
        RUN = 1'b1;
        DU  = v.du;
        if (!chained) COMP = v.pol;
        for (int cyc = 1; cyc <= len + 1; cyc++) begin
            if (!(chained && cyc == 1)) step();
            if (cyc <= len) begin
                if (cyc <= A)              exp_p = P_AZ;
                else if (cyc <= A + I)     exp_p = P_INT;
                else if (cyc < len)        exp_p = P_DEI;
                else                       exp_p = P_EOC;
                if (phases() !== exp_p && bad_cyc == 0) begin
                    bad_cyc = cyc;
                    bad_got = phases();
                    bad_exp = exp_p;
                end
                if (exp_p == P_DEI && REF_POL !== v.pol) refbad++;
            end else begin
                check({tag, "_phases"}, {bad_cyc, 3'b0, bad_got, 3'b0, bad_exp}, 32'h0);
                check({tag, "_ref_pol"}, refbad, 0);
                check({tag, "_after_eoc"}, phases(), RUN ? P_AZ : P_IDLE);
                check({tag, "_latched"}, {RESULT, POL, OVR, UR},
                      {v.e_res, v.e_pol, v.e_ovr, v.e_ur});
            end
            if (cyc <= A + I) COMP = v.pol;
            else              COMP = ((cyc - (A + I + 1)) < v.k) ? v.pol : ~v.pol;
            if (cyc == v.drop_at) RUN = 1'b0;
            if (!v.keep && cyc == len) RUN = 1'b0;
        end
        m_res   = v.e_res;
        m_pol   = v.e_pol;
        m_ovr   = v.e_ovr;
        m_ur    = v.e_ur;
        running = RUN;
    endtask

    initial begin : main
        bit   running;
        vec_t v;
        int   res;

        // Reset held for two edges with RUN low
        R = 1'b1; RUN = 1'b0; COMP = 1'b0; DU = 1'b0;
        step();
        step();
        check("reset_outputs", {phases(), REF_POL, RESULT, POL, OVR, UR}, 32'h0);
        R = 1'b0;
        step(); step(); step();
        check("idle_hold", {phases(), REF_POL, RESULT, POL, OVR, UR}, 32'h0);
        m_res = '0; m_pol = 1'b0; m_ovr = 1'b0; m_ur = 1'b0;

        //           pol k   du keep drop   res pol ovr ur
        tbl[0] = '{1'b1, 7,  1'b1, 1'b0, 0,   12'd7,  1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 25, 1'b1, 1'b0, 0,   12'd20, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 2,  1'b1, 1'b0, 0,   12'd2,  1'b1, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 5,  1'b0, 1'b0, 0,   12'd2,  1'b1, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 20, 1'b1, 1'b1, 0,   12'd20, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 21, 1'b1, 1'b1, 0,   12'd20, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 0,  1'b1, 1'b1, 0,   12'd0,  1'b0, 1'b0, 1'b1};
        tbl[7] = '{1'b1, 3,  1'b1, 1'b1, A+2, 12'd3,  1'b1, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 9,  1'b1, 1'b0, 0,   12'd9,  1'b0, 1'b0, 1'b0};

        running = 1'b0;
        for (int i = 0; i < 9; i++) begin
            convert(tbl[i], running, $sformatf("vec%0d", i), running);
        end

        // Randomized conversions against the conversion-level model
        for (int n = 0; n < 30; n++) begin
            v.pol     = 1'($urandom_range(0, 1));
            v.k       = int'($urandom_range(0, DM + 4));
            v.du      = ($urandom_range(0, 3) != 0);
            v.keep    = (n != 29) && ($urandom_range(0, 1) != 0);
            v.drop_at = 0;
            res       = (v.k <= DM) ? v.k : DM;
            if (v.du) begin
                v.e_res = CW'(res);
                v.e_pol = v.pol;
                v.e_ovr = (v.k > DM);
                v.e_ur  = (res < UL) && (v.k <= DM);
            end else begin
                v.e_res = m_res;
                v.e_pol = m_pol;
                v.e_ovr = m_ovr;
                v.e_ur  = m_ur;
            end
            convert(v, running, $sformatf("rnd%0d", n), running);
        end

        // Reset asserted in the middle of DEINT, then a fresh conversion
        RUN = 1'b1; DU = 1'b1; COMP = 1'b1;
        for (int cyc = 1; cyc <= A + I + 3; cyc++) step();
        check("abort_in_deint", phases(), P_DEI);
        R = 1'b1;
        step();
        check("abort_outputs", {phases(), REF_POL, RESULT, POL, OVR, UR}, 32'h0);
        R = 1'b0;
        step();
        check("restart_az", phases(), P_AZ);
        m_res = '0; m_pol = 1'b0; m_ovr = 1'b0; m_ur = 1'b0;
        v = '{1'b1, 4, 1'b1, 1'b0, 0, 12'd4, 1'b1, 1'b0, 1'b0};
        convert(v, 1'b1, "restart", running);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
